// File: rtl/grayscale_to_color.sv
// -----------------------------------------------------------------------------
// grayscale_to_color
//   Two-stage streaming colormap. 8-bit grayscale pixels arrive on a
//   valid/ready input and leave as 8-bit RGB on a valid/ready output.
//   mode 0 replicates the gray value into all three channels. mode 1 applies a
//   black-red-yellow-white heat map. mode is latched at column 0 and held for
//   the whole row.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   mode       : colormap select (0 gray, 1 heat), sampled at column 0
//   in_valid   : in_gray holds a pixel
//   in_gray    : 8-bit unsigned grayscale pixel
//   in_ready   : block accepts a pixel this cycle (= pipeline advance)
//   out_valid  : out_r/g/b/out_last hold a pixel
//   out_ready  : sink accepts the output pixel
//   out_r/g/b  : colour channels
//   out_last   : pixel is column SIZE-1 of its row
//   row_count  : row index of the pixel currently being accepted
//   frame_done : one-cycle pulse on the output handshake of the frame's last pixel
// -----------------------------------------------------------------------------
module grayscale_to_color #(
   parameter int unsigned SIZE = 100,
   parameter int unsigned ROWS = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic        in_valid,
   input  logic [7:0]  in_gray,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_r,
   output logic [7:0]  out_g,
   output logic [7:0]  out_b,
   output logic        out_last,
   output logic [15:0] row_count,
   output logic        frame_done
);

   localparam int unsigned COL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [COL_W-1:0] r_col;
   logic [15:0]      r_row;
   logic             r_mode_row;

   logic             r_s1_valid;
   logic [7:0]       r_s1_gray;
   logic             r_s1_last;
   logic             r_s1_frame_end;
   logic             r_s1_mode;

   logic             r_s2_frame_end;

   logic             w_advance;
   logic             w_in_hs;
   logic             w_col_first;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_mode_eff;

   logic [9:0]       w_g10;
   logic [9:0]       w_t_lo;
   logic [9:0]       w_t_mid;
   logic [9:0]       w_t_hi;
   logic [7:0]       w_r;
   logic [7:0]       w_g;
   logic [7:0]       w_b;

   // Both stages move together whenever the output register is free or drains.
   assign w_advance   = !out_valid || out_ready;
   assign in_ready    = w_advance;
   assign w_in_hs     = in_valid && w_advance;

   assign w_col_first = (r_col == '0);
   assign w_col_last  = (r_col == COL_W'(SIZE - 1));
   assign w_row_last  = (r_row == 16'(ROWS - 1));
   // Column 0 takes the live mode; later columns reuse the row's latched mode.
   assign w_mode_eff  = w_col_first ? mode : r_mode_row;

   assign row_count   = r_row;
   assign frame_done  = out_valid && out_ready && r_s2_frame_end;

   // Column/row position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col      <= '0;
         r_row      <= '0;
         r_mode_row <= 1'b0;
      end else if (w_in_hs) begin
         if (w_col_first) begin
            r_mode_row <= mode;
         end
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? 16'd0 : r_row + 16'd1;
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // S1: accepted pixel plus its position flags and the mode it maps with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid     <= 1'b0;
         r_s1_gray      <= 8'd0;
         r_s1_last      <= 1'b0;
         r_s1_frame_end <= 1'b0;
         r_s1_mode      <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid <= w_in_hs;
         if (w_in_hs) begin
            r_s1_gray      <= in_gray;
            r_s1_last      <= w_col_last;
            r_s1_frame_end <= w_col_last && w_row_last;
            r_s1_mode      <= w_mode_eff;
         end
      end
   end

   // 10-bit products: 3*255 = 765 never overflows; each band's result is <= 255.
   assign w_g10   = {2'b00, r_s1_gray};
   assign w_t_lo  = 10'd3 * w_g10;
   assign w_t_mid = 10'd3 * (w_g10 - 10'd85);
   assign w_t_hi  = 10'd3 * (w_g10 - 10'd170);

   always_comb begin
      w_r = r_s1_gray;
      w_g = r_s1_gray;
      w_b = r_s1_gray;
      if (r_s1_mode) begin
         if (w_g10 < 10'd85) begin
            w_r = 8'(w_t_lo);
            w_g = 8'd0;
            w_b = 8'd0;
         end else if (w_g10 < 10'd170) begin
            w_r = 8'd255;
            w_g = 8'(w_t_mid);
            w_b = 8'd0;
         end else begin
            w_r = 8'd255;
            w_g = 8'd255;
            w_b = 8'(w_t_hi);
         end
      end
   end

   // S2: output register. Data only loads on a real pixel so bubbles keep the
   // last values but never raise out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_r          <= 8'd0;
         out_g          <= 8'd0;
         out_b          <= 8'd0;
         out_last       <= 1'b0;
         r_s2_frame_end <= 1'b0;
      end else if (w_advance) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            out_r          <= w_r;
            out_g          <= w_g;
            out_b          <= w_b;
            out_last       <= r_s1_last;
            r_s2_frame_end <= r_s1_frame_end;
         end
      end
   end

endmodule

// File: doc/grayscale_to_color.md
GRAYSCALE_TO_COLOR -- requirements
Module: grayscale_to_color

Interface
REQ-001 Parameter SIZE shall default to 100 and set the pixels per row.
REQ-002 Parameter ROWS shall default to 100 and set the rows per frame.
REQ-003 clk shall be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 rst_n shall be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 mode shall be an input, 1 bit, selecting the colormap: 0 = gray replicate, 1 = heat map.
REQ-006 in_valid shall be an input, 1 bit, indicating that in_gray holds a pixel.
REQ-007 in_gray shall be an input, 8 bits, the unsigned grayscale pixel.
REQ-008 in_ready shall be an output, 1 bit, indicating that the block accepts a pixel this cycle.
REQ-009 out_valid shall be an output, 1 bit, indicating that out_r, out_g, out_b and out_last hold a pixel.
REQ-010 out_ready shall be an input, 1 bit, indicating that the sink accepts the output pixel.
REQ-011 out_r, out_g and out_b shall each be an output, 8 bits, the colour channels.
REQ-012 out_last shall be an output, 1 bit, marking column SIZE-1 of a row.
REQ-013 row_count shall be an output, 16 bits, the index of the row currently being accepted.
REQ-014 frame_done shall be an output, 1 bit, a one-cycle pulse at the end of a frame.

Function
REQ-015 The datapath shall be a 2-stage pipeline: S1 registers pixel, column flags and mode; S2 registers the computed RGB.
REQ-016 Define advance = !out_valid || out_ready; both stages shall shift only on advance, and in_ready shall equal advance (combinational).
REQ-017 An input handshake occurs when in_valid && in_ready; a pixel accepted at edge k shall be presented with out_valid high after edge k+1 if no stall occurs.
REQ-018 When out_valid && !out_ready, out_r, out_g, out_b and out_last shall hold stable and S1 shall hold.
REQ-019 On advance without an input handshake, S1 shall load a bubble (invalid); bubbles shall never assert out_valid.
REQ-020 A column counter shall increment on each input handshake and wrap from SIZE-1 to 0.
REQ-021 The row counter shall increment on the handshake at column SIZE-1 and wrap from ROWS-1 to 0.
REQ-022 mode shall be sampled only on the handshake at column 0 and held for the whole row; mid-row changes of mode shall have no effect until the next row.
REQ-023 In mode 0, each output channel shall equal g.
REQ-024 In mode 1, for g < 85 the output shall be R = 3g, G = 0, B = 0.
REQ-025 In mode 1, for 85 <= g < 170 the output shall be R = 255, G = 3(g-85), B = 0.
REQ-026 In mode 1, for g >= 170 the output shall be R = 255, G = 255, B = 3(g-170).
REQ-027 Mode-1 arithmetic shall use at least 10-bit intermediates and no truncation; the maximum result 3*85 = 255 shall fit in 8 bits.
REQ-028 out_last shall accompany the pixel accepted at column SIZE-1 through the pipeline.
REQ-029 frame_done shall pulse for exactly one cycle on the output handshake of the out_last pixel of row ROWS-1.
REQ-030 Simultaneous input and output handshakes shall both complete in the same cycle with no loss or duplication.

Reset
REQ-031 While rst_n is low: out_valid = 0, out_r = out_g = out_b = 0, out_last = 0, frame_done = 0, row_count = 0, column counter = 0, both stages invalid, latched mode = 0.
REQ-032 Assertion of rst_n mid-row or mid-stall shall discard all in-flight pixels immediately; after release the next accepted pixel shall be column 0 of row 0.
REQ-033 in_ready shall be 1 during reset (both stages empty) and no handshake shall be counted while rst_n is low.

Verification
REQ-034 Mode 0 streaming: mode 0, out_ready = 1, inputs 0, 128, 255 on consecutive cycles -> RGB (0,0,0), (128,128,128), (255,255,255) two cycles later, back-to-back.
REQ-035 Mode 1 boundaries: g = 84, 85, 169, 170, 255 -> (252,0,0), (255,0,0), (255,252,0), (255,255,0), (255,255,255).
REQ-036 Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> at most 2 pixels are accepted, outputs are stable, and the order is preserved after release.
REQ-037 Row/frame: SIZE = 4, ROWS = 2, 8 pixels -> out_last on pixels 3 and 7, row_count goes 0->1->0, and one frame_done pulse occurs with pixel 7.
REQ-038 Mode change mid-row: switch mode at column 2 -> that row stays in the old mapping and the new mapping starts at the next column 0.
REQ-039 Reset mid-frame: pull rst_n low during a stall at column 2 -> outputs clear asynchronously, and the first pixel after release gets column 0 and row_count 0.
